uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port data_out  output  8  last correctly framed byte.
REQ-006 SHALL have port data_rdy  output  1  one-cycle pulse when data_out is updated; drives the downstream packet parser's byte strobe.
REQ-007 SHALL have port framing_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer, preset to 1; all decoding uses the synchronized value rx_s.
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (only when parity is compiled in), STOP and WAIT_HIGH.
REQ-011 IDLE -> START on rx_s == 0; a bit counter of width $clog2(CLKS_PER_BIT) clears on entry.
REQ-012 START SHALL sample rx_s after CLKS_PER_BIT/2 cycles (integer division); 0 -> DATA, 1 -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA SHALL sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register; a 3-bit index wraps 7 -> 0 on exit.
REQ-014 STOP SHALL sample once after CLKS_PER_BIT cycles; 1 with no parity error -> load data_out, pulse data_rdy, go to IDLE.
REQ-015 STOP sample 0 SHALL pulse framing_err, leave data_out unchanged, assert no data_rdy, and enter WAIT_HIGH.
REQ-016 WAIT_HIGH SHALL stay until rx_s == 1 (line break tolerated), then go to IDLE.
REQ-017 data_rdy SHALL assert exactly the cycle after the STOP sample cycle; data_out SHALL hold until the next good byte.
REQ-018 data_rdy, framing_err and parity_err SHALL each be high for exactly one cycle per event and never together.
REQ-019 A new start bit detected in IDLE in the cycle data_rdy is high SHALL be accepted; back-to-back frames with a single stop bit SHALL not be lost.

Reset
REQ-020 rst_n low SHALL immediately force: state IDLE, synchronizer flops 1, counters 0, shift register 0, data_out 8'h00, all pulses 0.
REQ-021 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes only on a fresh falling edge.

Configuration
REQ-022 Macro UART_RX_PARITY_EN defined: one even-parity bit SHALL follow bit 7 and be sampled in PARITY.
REQ-023 With UART_RX_PARITY_EN, a mismatch SHALL pulse parity_err at the data_rdy timing, suppress data_rdy and the data_out update, and go to IDLE (or WAIT_HIGH on a simultaneous framing error, where framing_err takes priority).
REQ-024 Macro undefined: no PARITY state, frame is 10 bits, parity_err tied 0.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum typedef, the default CLKS_PER_BIT constant and the frame bit count constant.
REQ-026 The synchronizer SHALL be a sub-module named sync_2ff (1-bit, reset value parameter).

Verification (bench uses CLKS_PER_BIT=16)
REQ-027 Send 8'hA5 with a good stop bit -> data_out=8'hA5 and a single data_rdy pulse 1 cycle after the stop midpoint (about 152 cycles after the falling edge, plus synchronizer delay).
REQ-028 Send 8'h3C then 8'hFF back-to-back -> two data_rdy pulses with data_out 8'h3C then 8'hFF.
REQ-029 Low glitch of 4 cycles on rx -> return to IDLE, no pulse on any output.
REQ-030 Send 8'h55 with stop bit 0, then hold rx low for 40 bit times -> one framing_err pulse, data_out unchanged, no further events until rx returns high.
REQ-031 Assert rst_n low at data bit 4 of 8'h0F, release, then send 8'h81 -> data_out=8'h00 after reset, then 8'h81 with one data_rdy pulse.
REQ-032 With UART_RX_PARITY_EN: send 8'h07 with parity bit 0 -> one parity_err pulse, no data_rdy; with parity bit 1 -> data_rdy pulse, data_out=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
// Purpose: FSM state encoding, default bit period and frame geometry.
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit after bit 7).
package uart_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  localparam int unsigned DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // start + data + optional parity + one stop bit
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous bit
// Ports: clk_i system clock, rst_ni async active-low reset,
//        d_i asynchronous input, q_o synchronized output.
// Both flops load RESET_VAL while reset is asserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver, LSB first, one stop bit
// Ports: clk          system clock
//        rst_n        async active-low reset
//        rx           asynchronous serial line (idles high)
//        data_out     last correctly framed byte
//        data_rdy     one-cycle strobe when data_out updates
//        framing_err  one-cycle strobe when the stop bit samples low
//        parity_err   one-cycle strobe on even-parity mismatch (0 without parity)
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after bit 7.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_rdy,
  output logic       framing_err,
  output logic       parity_err
);

  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  // index of the last data bit: frame minus start, stop and parity bits
  localparam int unsigned LAST_IDX = FRAME_BITS - PARITY_BITS - 3;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 data_rdy_q, data_rdy_d;
  logic                 framing_err_q, framing_err_d;
  logic                 bit_done;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic parity_err_q, parity_err_d;
  logic parity_bad;

  // even parity: received parity bit must equal the XOR of the data bits
  assign parity_bad = par_bit_q ^ (^shift_q);
`endif

  assign bit_done = (cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_out_q    <= 8'h00;
      data_rdy_q    <= 1'b0;
      framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_rdy_q    <= data_rdy_d;
      framing_err_q <= framing_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q     <= par_bit_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_rdy_d    = 1'b0;
    framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d     = par_bit_q;
    parity_err_d  = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // sample near the middle of the start bit to reject short glitches
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;  // wraps 7 -> 0 on the last bit
          if (idx_q == 3'(LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // outcome strobes are registered, so they appear the cycle after this sample
      ST_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (!rx_s) begin
            framing_err_d = 1'b1;
            state_d       = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad) begin
            parity_err_d = 1'b1;
            state_d      = ST_IDLE;
`endif
          end else begin
            data_out_d = shift_q;
            data_rdy_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // a held-low line (break) must not be read as a new start bit
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data_out    = data_out_q;
  assign data_rdy    = data_rdy_q;
  assign framing_err = framing_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
